alu_acc_seq: RTL and testbench
==============================

// Module: alu_acc_seq
// PURPOSE
//   Control sequencer that drives the accumulator ALU's one-hot control strobes C8..C21.
//   Accepts one ALU command at a time over a valid/ready handshake and emits the matching strobe.
//   Multi-bit shifts repeat the shift strobe; MUL/DIV are followed by a configurable stall.
//   Signals completion with a one-cycle done pulse. Sits between the microinstruction decoder and the ALU/ACC datapath.
// PARAMETERS
//   MULDIV_WAIT  2  stall cycles after a C15/C16 strobe before done; 0 is legal
//   AMT_W        4  width of the shift-amount field
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      sequencer can accept a command (high only in IDLE)
//   cmd_op     in   4      0 CLR,1 ADD,2 SUB,3 MUL,4 DIV,5 SHR,6 SHL,7 AND,8 OR,9 NOT; 10-15 illegal
//   cmd_amt    in   AMT_W  shift count for SHR/SHL; ignored for other ops
//   br_zero    in   1      BR operand is zero (used only with ALU_SEQ_DIV0_CHK_EN)
//   c8,c9,c13  out  1      CLR/ADD/SUB strobes
//   c15..c21   out  1      MUL,DIV,SHR,SHL,AND,OR,NOT strobes (one port each)
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle completion pulse
//   err        out  1      set with done for an illegal/rejected op; cleared on next accept
// BEHAVIOUR
//   Reset: state IDLE; all strobes, busy, done, err = 0; cmd_ready = 1. All outputs are registered.
//   Accept on clk edge T when cmd_valid & cmd_ready. Latch op and amt; clear err.
//   FSM states: IDLE, ISSUE, SHIFT, WAIT, DONE.
//     IDLE  -> ISSUE on accept.
//     ISSUE (T+1): for ops 0-4 and 7-9, assert exactly one strobe for 1 cycle.
//           Single-cycle ops go to DONE.
//           MUL/DIV go to WAIT, or to DONE if MULDIV_WAIT=0.
//           SHR/SHL with amt>0: strobe c17/c18, load counter = amt-1.
//             Go to SHIFT if counter>0, else DONE.
//           SHR/SHL with amt=0: no strobe; go to DONE.
//           Illegal op: no strobe; set err; go to DONE.
//     SHIFT: same shift strobe every cycle; decrement counter; go to DONE when counter hits 0.
//           Strobe count per command is exactly amt.
//     WAIT:  no strobe; counter runs MULDIV_WAIT cycles, then DONE.
//     DONE:  done=1 for one cycle; err is valid this cycle; -> IDLE.
//   Latency from accept edge to done high:
//     single-cycle ops: T+2
//     MUL/DIV: T+2+MULDIV_WAIT
//     shift: T+1+max(amt,1)
//   Back-to-back commands: min spacing 3 cycles, since cmd_ready is low from ISSUE through DONE.
//   At most one strobe is high in any cycle. Strobes are never high in IDLE, WAIT or DONE.
//   Changes to cmd_* while busy are ignored. cmd_valid held high across done is accepted on return to IDLE.
//   Reset mid-operation: outputs clear immediately (async). No done pulse. Pending command is lost.
//   Shift counter is AMT_W bits. Max amt (2^AMT_W-1) does not wrap.
// CONFIGURATION
//   ALU_SEQ_DIV0_CHK_EN defined:
//     DIV accepted with br_zero=1 (sampled at the accept edge) issues no c16 strobe.
//     It skips WAIT and goes to DONE with err=1 (done at T+2).
//   ALU_SEQ_DIV0_CHK_EN undefined:
//     br_zero is ignored; DIV always strobes c16 and waits MULDIV_WAIT.
// STRUCTURE
//   Package alu_seq_pkg: op encodings (OP_CLR..OP_NOT), OP_W=4, FSM state typedef/localparams.
//   Sub-module alu_seq_strobe_dec: combinational op -> 10-bit one-hot strobe vector plus illegal flag.
//     The top module registers and gates this vector.
// TESTING
//   ADD (op=1) accepted at cycle 0 -> c9=1 only at cycle 1, done=1 at cycle 2, err=0.
//   SHL op=6, amt=3 -> c18 high cycles 1-3, done at 4; amt=0 -> no strobe, done at 2.
//   MUL op=3, MULDIV_WAIT=2 -> c15 at 1, no strobes cycles 2-3, done at 4; cmd_ready low cycles 1-4.
//   op=12 -> no strobe, done and err at 2; next ADD accept clears err.
//   DIV op=4, br_zero=1:
//     with macro: no c16, err=1, done at 2.
//     without macro: c16 at 1, done at 4.
//   SHR amt=15, rst pulsed at cycle 5 -> c17 drops immediately, no done, cmd_ready=1 after reset.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings, FSM states and helpers for the ALU control sequencer
package alu_seq_pkg;

    localparam int OP_W        = 4;
    localparam int NUM_STROBES = 10;

    typedef enum logic [OP_W-1:0] {
        OP_CLR = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_SHR = 4'd5,
        OP_SHL = 4'd6,
        OP_AND = 4'd7,
        OP_OR  = 4'd8,
        OP_NOT = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_strobe_dec.sv
// rtl/alu_seq_strobe_dec.sv - combinational op to one-hot strobe vector with illegal-op flag
module alu_seq_strobe_dec
    import alu_seq_pkg::*;
(
    input  logic [OP_W-1:0]        op,
    output logic [NUM_STROBES-1:0] strobe,
    output logic                   illegal
);

    // Bit i of the vector corresponds to op code i (CLR..NOT).
    always_comb begin
        strobe = '0;
        for (int i = 0; i < NUM_STROBES; i++) begin
            if (op == OP_W'(i)) begin
                strobe[i] = 1'b1;
            end
        end
        illegal = ~|strobe;
    end

endmodule

// File: rtl/alu_acc_seq.sv
// rtl/alu_acc_seq.sv - ALU/ACC control sequencer driving one-hot strobes C8..C21
// Optional divide-by-zero rejection is enabled by defining ALU_SEQ_DIV0_CHK_EN.
module alu_acc_seq
    import alu_seq_pkg::*;
#(
    parameter int MULDIV_WAIT = 2,
    parameter int AMT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             br_zero,
    output logic             c8,
    output logic             c9,
    output logic             c13,
    output logic             c15,
    output logic             c16,
    output logic             c17,
    output logic             c18,
    output logic             c19,
    output logic             c20,
    output logic             c21,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WAIT_W    = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
    localparam int WAIT_LOAD = (MULDIV_WAIT > 0) ? MULDIV_WAIT - 1 : 0;

    state_e                 state_q, state_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [AMT_W-1:0]       shift_cnt_q, shift_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [NUM_STROBES-1:0] strobe_q, strobe_d;
    logic                   fault_q, fault_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic [NUM_STROBES-1:0] dec_strobe;
    logic                   dec_illegal;
    logic                   div0;
    logic                   accept;

    alu_seq_strobe_dec u_dec (
        .op      (cmd_op),
        .strobe  (dec_strobe),
        .illegal (dec_illegal)
    );

`ifdef ALU_SEQ_DIV0_CHK_EN
    assign div0 = (cmd_op == OP_DIV) && br_zero;
`else
    logic unused_br_zero;
    assign unused_br_zero = br_zero;
    assign div0           = 1'b0;
`endif

    assign accept = cmd_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shift_cnt_d = shift_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        fault_d     = fault_q;
        err_d       = err_q;
        strobe_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_ISSUE;
                    op_d        = cmd_op;
                    err_d       = 1'b0;
                    fault_d     = dec_illegal || div0;
                    // Counter holds strobes still owed after the ISSUE cycle.
                    shift_cnt_d = (cmd_amt == '0) ? '0 : cmd_amt - AMT_W'(1);
                    strobe_d    = dec_strobe;
                    if ((is_shift(cmd_op) && (cmd_amt == '0)) || div0) begin
                        strobe_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (fault_q) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (is_shift(op_q) && (shift_cnt_q != '0)) begin
                    state_d     = ST_SHIFT;
                    shift_cnt_d = shift_cnt_q - AMT_W'(1);
                    strobe_d    = strobe_q;
                end else if (is_muldiv(op_q) && (MULDIV_WAIT > 0)) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(WAIT_LOAD);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (shift_cnt_q != '0) begin
                    shift_cnt_d = shift_cnt_q - AMT_W'(1);
                    strobe_d    = strobe_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they align with it.
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            shift_cnt_q <= '0;
            wait_cnt_q  <= '0;
            strobe_q    <= '0;
            fault_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            shift_cnt_q <= shift_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            strobe_q    <= strobe_d;
            fault_q     <= fault_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign c8        = strobe_q[0];
    assign c9        = strobe_q[1];
    assign c13       = strobe_q[2];
    assign c15       = strobe_q[3];
    assign c16       = strobe_q[4];
    assign c17       = strobe_q[5];
    assign c18       = strobe_q[6];
    assign c19       = strobe_q[7];
    assign c20       = strobe_q[8];
    assign c21       = strobe_q[9];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// tb/tb_alu_acc_seq.sv - scoreboard bench for alu_acc_seq
module tb_alu_acc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_amt;
    logic       br_zero;
    logic       c8, c9, c13, c15, c16, c17, c18, c19, c20, c21;
    logic       busy, done, err;

    alu_acc_seq #(.MULDIV_WAIT(2), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .br_zero(br_zero),
        .c8(c8), .c9(c9), .c13(c13), .c15(c15), .c16(c16), .c17(c17),
        .c18(c18), .c19(c19), .c20(c20), .c21(c21),
        .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [9:0] mask;
        int         cnt;
        int         lat;
        logic       err;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    logic [9:0] strobes;
    assign strobes = {c21, c20, c19, c18, c17, c16, c15, c13, c9, c8};

    bit         inflight = 0;
    int         cyc, scount, first;
    logic [9:0] seen;
    bit         multi, ready_bad;
    exp_t       e;

    // Monitor: samples mid-cycle; cycle 1 is the first cycle after the accept edge.
    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
        end else begin
            if (inflight) begin
                cyc++;
                if (strobes != 10'd0) begin
                    seen |= strobes;
                    scount++;
                    if (first < 0) first = cyc;
                    if ($countones(strobes) > 1) multi = 1;
                end
                if (cmd_ready || !busy) ready_bad = 1;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_mask"}, int'(seen), int'(e.mask));
                        check({e.name, "_strobe_count"}, scount, e.cnt);
                        check({e.name, "_done_cycle"}, cyc, e.lat);
                        check({e.name, "_err"}, int'(err), int'(e.err));
                        check({e.name, "_first_strobe"}, first, (e.cnt > 0) ? 1 : -1);
                        check({e.name, "_single_strobe"}, int'(multi), 0);
                        check({e.name, "_ready_low_busy_high"}, int'(ready_bad), 0);
                    end
                    inflight = 0;
                end
            end else if (strobes != 10'd0 || done) begin
                check("idle_activity", int'({strobes, done}), 0);
            end
            if (cmd_valid && cmd_ready) begin
                inflight  = 1;
                cyc       = 0;
                scount    = 0;
                first     = -1;
                seen      = '0;
                multi     = 0;
                ready_bad = 0;
            end
        end
    end

    task automatic wait_ready(input string name);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] amt, input logic bz,
                        input logic [9:0] mask, input int cnt, input int lat,
                        input logic xerr, input string name);
        wait_ready(name);
        cmd_op    = op;
        cmd_amt   = amt;
        br_zero   = bz;
        cmd_valid = 1'b1;
        sb.push_back('{mask, cnt, lat, xerr, name});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom_range(0, 15));
        cmd_amt   = 4'($urandom_range(0, 15));
        br_zero   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sb.size() != 0 || inflight) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0 || inflight) check({name, "_drain_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_amt   = 4'd0;
        br_zero   = 1'b0;
        #12;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_strobes", int'(strobes), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send(4'd1, 4'd0, 1'b0, 10'b00_0000_0010, 1, 2, 1'b0, "add");
        send(4'd6, 4'd3, 1'b0, 10'b00_0100_0000, 3, 4, 1'b0, "shl3");
        send(4'd6, 4'd0, 1'b0, 10'b00_0000_0000, 0, 2, 1'b0, "shl0");
        send(4'd3, 4'd0, 1'b0, 10'b00_0000_1000, 1, 4, 1'b0, "mul");
        send(4'd12, 4'd0, 1'b0, 10'b00_0000_0000, 0, 2, 1'b1, "ill12");
        drain("ill12");
        repeat (3) @(posedge clk);
        #1;
        check("err_held_until_accept", int'(err), 1);
        send(4'd1, 4'd7, 1'b0, 10'b00_0000_0010, 1, 2, 1'b0, "add_clr_err");
`ifdef ALU_SEQ_DIV0_CHK_EN
        send(4'd4, 4'd0, 1'b1, 10'b00_0000_0000, 0, 2, 1'b1, "div_bz");
`else
        send(4'd4, 4'd0, 1'b1, 10'b00_0001_0000, 1, 4, 1'b0, "div_bz");
`endif
        send(4'd4, 4'd0, 1'b0, 10'b00_0001_0000, 1, 4, 1'b0, "div");
        send(4'd5, 4'd1, 1'b0, 10'b00_0010_0000, 1, 2, 1'b0, "shr1");
        send(4'd5, 4'd15, 1'b0, 10'b00_0010_0000, 15, 16, 1'b0, "shr15");
        send(4'd0, 4'd0, 1'b0, 10'b00_0000_0001, 1, 2, 1'b0, "clr");
        send(4'd2, 4'd0, 1'b0, 10'b00_0000_0100, 1, 2, 1'b0, "sub");
        send(4'd7, 4'd0, 1'b0, 10'b00_1000_0000, 1, 2, 1'b0, "and");
        send(4'd8, 4'd0, 1'b0, 10'b01_0000_0000, 1, 2, 1'b0, "or");
        send(4'd9, 4'd0, 1'b0, 10'b10_0000_0000, 1, 2, 1'b0, "not");
        send(4'd15, 4'd0, 1'b0, 10'b00_0000_0000, 0, 2, 1'b1, "ill15");
        drain("main");

        // Reset during a long shift: accept at edge 0, reset in cycle 5.
        wait_ready("rst_mid");
        cmd_op    = 4'd5;
        cmd_amt   = 4'd15;
        br_zero   = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_c17_before_rst", int'(c17), 1);
        rst = 1'b1;
        #1;
        check("mid_c17_cleared", int'(c17), 0);
        check("mid_done_low", int'(done), 0);
        check("mid_cmd_ready", int'(cmd_ready), 1);
        check("mid_busy_low", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_pending", sb.size(), 0);

        send(4'd1, 4'd0, 1'b0, 10'b00_0000_0010, 1, 2, 1'b0, "add_after_rst");
        drain("final");
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
